bidir_duplex_fifo_core: RTL and testbench

Parametrised loopback core for the host-link throughput tests. It buffers pipe-in words in an internal synchronous FIFO, returns them on pipe-out, and times transfers with a 64-bit cycle counter. It also reports occupancy, thresholds and sticky error flags, and optionally checks read-back data against a counting pattern. It sits between the okPipeIn/okPipeOut endpoints and the wire/trigger endpoints of a test top level.

---
 rtl/bidir_fifo_pkg.sv | 15 +
 rtl/bidir_duplex_fifo_core_if.sv | 37 +++
 rtl/bidir_fifo_ram.sv | 28 ++
 rtl/bidir_duplex_fifo_core.sv | 195 +++++++++++++++++++
 tb/tb_bidir_duplex_fifo_core.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bidir_fifo_pkg.sv
// Shared types and constants for the bidirectional duplex FIFO core.
// The optional read-back checker is enabled by defining PATTERN_CHECK_EN.
package bidir_fifo_pkg;

    localparam int TIMER_W    = 64;
    localparam int ERR_W      = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/bidir_duplex_fifo_core_if.sv
// Pipe-side bus of the duplex FIFO core: write/read requests, read data and status.
interface bidir_duplex_fifo_core_if
    import bidir_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    // Handshake: a write is taken at a rising edge iff wr_en && !full, a read iff
    // rd_en && !empty; the core answers with a one-cycle wr_ack / valid pulse after that edge.
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              wr_ack;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, valid, wr_ack, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, valid, wr_ack, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/bidir_fifo_ram.sv
// Simple dual-port memory with registered read and no reset, shaped for block-RAM inference.
module bidir_fifo_ram
    import bidir_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bidir_duplex_fifo_core.sv
// Loopback FIFO core with occupancy flags, sticky errors and a 64-bit transfer timer.
// Defining PATTERN_CHECK_EN builds a counting-pattern checker on the read-back data.
module bidir_duplex_fifo_core
    import bidir_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = 2**ADDR_W - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                okClk,
    input  logic                reset_n,
    input  logic                clear,
    bidir_duplex_fifo_core_if.slave fifo,
    input  logic                start_timer,
    input  logic                stop_timer,
    output logic                timer_on,
    output logic [TIMER_W-1:0]  clk_counts,
    input  logic [DATA_W-1:0]   pattern_seed,
    input  logic                reset_pattern,
    output logic [ERR_W-1:0]    error_count,
    output timer_state_t        timer_state
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(1 << ADDR_W);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              valid_q;
    logic              wr_ack_q;
    logic              ovf_q;
    logic              unf_q;
    logic              ever_read;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] dout_w;
    logic              is_full;
    logic              is_empty;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);
    // clear outranks traffic, so nothing reaches the RAM in a clear cycle
    assign wr_acc   = fifo.wr_en && !is_full && !clear;
    assign rd_acc   = fifo.rd_en && !is_empty && !clear;

    bidir_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (okClk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (fifo.din),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ever_read <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            wr_ack_q <= wr_acc;
            valid_q  <= rd_acc;
            if (fifo.wr_en && is_full)  ovf_q <= 1'b1;
            if (fifo.rd_en && is_empty) unf_q <= 1'b1;
            if (rd_acc) ever_read <= 1'b1;
        end
    end

    // The RAM output register has no reset; mask it until the first read lands.
    assign dout_w            = ever_read ? ram_q : '0;
    assign fifo.dout         = dout_w;
    assign fifo.valid        = valid_q;
    assign fifo.wr_ack       = wr_ack_q;
    assign fifo.full         = is_full;
    assign fifo.empty        = is_empty;
    assign fifo.almost_full  = (count_q >= AFULL_C);
    assign fifo.almost_empty = (count_q <= AEMPTY_C);
    assign fifo.count        = count_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;

    timer_state_t state_q;
    timer_state_t state_d;
    logic         tick;

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_timer && !stop_timer) begin
                    state_d = RUN;
                    tick    = 1'b1;
                end
            end
            RUN: begin
                tick = 1'b1;
                if (stop_timer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            clk_counts <= '0;
        end else if (clear) begin
            clk_counts <= '0;
        end else if (tick) begin
            clk_counts <= clk_counts + TIMER_W'(1);
        end
    end

    assign timer_on    = (state_q == RUN);
    assign timer_state = state_q;

`ifdef PATTERN_CHECK_EN
    logic [DATA_W-1:0] exp_r;
    logic              reload_q;
    logic [DATA_W-1:0] cur_exp;
    logic [ERR_W-1:0]  err_q;

    // After reset the seed is taken live until the first reload or compare.
    assign cur_exp = reload_q ? pattern_seed : exp_r;

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            exp_r    <= '0;
            reload_q <= 1'b1;
            err_q    <= '0;
        end else if (clear) begin
            exp_r    <= pattern_seed;
            reload_q <= 1'b0;
            err_q    <= '0;
        end else begin
            if (valid_q && (dout_w != cur_exp) && (err_q != '1)) begin
                err_q <= err_q + ERR_W'(1);
            end
            if (reset_pattern) begin
                exp_r    <= pattern_seed;
                reload_q <= 1'b0;
            end else if (valid_q) begin
                exp_r    <= cur_exp + DATA_W'(1);
                reload_q <= 1'b0;
            end
        end
    end

    assign error_count = err_q;
`else
    logic unused_pattern;
    assign unused_pattern = ^{pattern_seed, reset_pattern};
    assign error_count    = '0;
`endif

endmodule

// File: tb/tb_bidir_duplex_fifo_core.sv
// Self-checking bench for bidir_duplex_fifo_core against a queue-based reference model.
module tb_bidir_duplex_fifo_core;
    import bidir_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset_n;
    logic          clear;
    logic          start_timer;
    logic          stop_timer;
    logic          timer_on;
    logic [63:0]   clk_counts;
    logic [DW-1:0] pattern_seed;
    logic          reset_pattern;
    logic [31:0]   error_count;
    timer_state_t  timer_state;

    int n_checks = 0;
    int n_errors = 0;

    bidir_duplex_fifo_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    bidir_duplex_fifo_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .okClk         (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .fifo          (bus),
        .start_timer   (start_timer),
        .stop_timer    (stop_timer),
        .timer_on      (timer_on),
        .clk_counts    (clk_counts),
        .pattern_seed  (pattern_seed),
        .reset_pattern (reset_pattern),
        .error_count   (error_count),
        .timer_state   (timer_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: stored words, last read word, sticky flags, timer, checker
    logic [DW-1:0] mdl_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_dout;
    bit            m_valid, m_wr_ack, m_ovf, m_unf, m_run;
    logic [63:0]   m_clk;
    logic [31:0]   m_err;
`ifdef PATTERN_CHECK_EN
    logic [DW-1:0] m_pat;
`endif

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        m_dout = '0; m_valid = 0; m_wr_ack = 0; m_ovf = 0; m_unf = 0; m_run = 0;
        m_clk = '0; m_err = '0;
`ifdef PATTERN_CHECK_EN
        m_pat = pattern_seed;
`endif
    endtask

    // driver: apply one cycle of inputs, advance the model, sample #1 after the edge
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit clr, input bit st, input bit sp, input bit rp);
        bit full_now, empty_now, wa, ra;
        bus.wr_en = w; bus.din = d; bus.rd_en = r;
        clear = clr; start_timer = st; stop_timer = sp; reset_pattern = rp;
        if (clr) begin
            mdl_q.delete();
            m_valid = 0; m_wr_ack = 0; m_ovf = 0; m_unf = 0; m_run = 0;
            m_clk = '0; m_err = '0;
`ifdef PATTERN_CHECK_EN
            m_pat = pattern_seed;
`endif
        end else begin
            full_now  = (mdl_q.size() == DEPTH);
            empty_now = (mdl_q.size() == 0);
            wa = w && !full_now;
            ra = r && !empty_now;
            if (w && full_now)  m_ovf = 1;
            if (r && empty_now) m_unf = 1;
`ifdef PATTERN_CHECK_EN
            if (m_valid && m_dout != m_pat && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
            if (rp) m_pat = pattern_seed;
            else if (m_valid) m_pat = m_pat + 1;
`endif
            if (ra) begin
                m_dout = mdl_q.pop_front();
                exp_q.push_back(m_dout);
            end
            m_valid  = ra;
            if (wa) mdl_q.push_back(d);
            m_wr_ack = wa;
            if (m_run) begin
                m_clk = m_clk + 1;
                if (sp) m_run = 0;
            end else if (st && !sp) begin
                m_run = 1;
                m_clk = m_clk + 1;
            end
        end
        @(posedge clk);
        #1;
        bus.wr_en = 0; bus.rd_en = 0; clear = 0;
        start_timer = 0; stop_timer = 0; reset_pattern = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset_n = 0;
        #12;
        @(negedge clk);
        reset_n = 1;
        model_reset();
        #1;
        n_checks += 13;
        if (bus.dout !== '0)          begin n_errors++; $display("FAIL rst_dout got %h exp 0", bus.dout); end
        if (bus.valid !== 1'b0)       begin n_errors++; $display("FAIL rst_valid got %b exp 0", bus.valid); end
        if (bus.wr_ack !== 1'b0)      begin n_errors++; $display("FAIL rst_wr_ack got %b exp 0", bus.wr_ack); end
        if (bus.full !== 1'b0)        begin n_errors++; $display("FAIL rst_full got %b exp 0", bus.full); end
        if (bus.empty !== 1'b1)       begin n_errors++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
        if (bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL rst_afull got %b exp 0", bus.almost_full); end
        if (bus.almost_empty !== 1'b1) begin n_errors++; $display("FAIL rst_aempty got %b exp 1", bus.almost_empty); end
        if (bus.count !== '0)         begin n_errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
        if (bus.overflow !== 1'b0)    begin n_errors++; $display("FAIL rst_ovf got %b exp 0", bus.overflow); end
        if (bus.underflow !== 1'b0)   begin n_errors++; $display("FAIL rst_unf got %b exp 0", bus.underflow); end
        if (timer_on !== 1'b0)        begin n_errors++; $display("FAIL rst_timer_on got %b exp 0", timer_on); end
        if (clk_counts !== 64'd0)     begin n_errors++; $display("FAIL rst_clk_counts got %0d exp 0", clk_counts); end
        if (error_count !== 32'd0)    begin n_errors++; $display("FAIL rst_error_count got %0d exp 0", error_count); end
    endtask

    task automatic test_basic();
        step(0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, DW'(32'h10 + i), 0, 0, 0, 0, 0);
            n_checks += 2;
            if (bus.wr_ack !== 1'b1)      begin n_errors++; $display("FAIL basic_wr_ack[%0d] got %b exp 1", i, bus.wr_ack); end
            if (bus.count !== CW'(i + 1)) begin n_errors++; $display("FAIL basic_count[%0d] got %0d exp %0d", i, bus.count, i + 1); end
        end
        n_checks++;
        if (bus.almost_empty !== 1'b0) begin n_errors++; $display("FAIL basic_aempty got %b exp 0", bus.almost_empty); end
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1, 0, 0, 0, 0);
            n_checks += 2;
            if (bus.valid !== 1'b1)          begin n_errors++; $display("FAIL basic_valid[%0d] got %b exp 1", i, bus.valid); end
            if (bus.dout !== DW'(32'h10 + i)) begin n_errors++; $display("FAIL basic_dout[%0d] got %h exp %h", i, bus.dout, 32'h10 + i); end
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL basic_empty got %b exp 1", bus.empty); end
        idle(1);
        n_checks++;
        if (bus.valid !== 1'b0) begin n_errors++; $display("FAIL basic_valid_pulse got %b exp 0", bus.valid); end
        exp_q.delete();
    endtask

    task automatic test_full();
        logic [DW-1:0] want;
        step(0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, DW'($urandom), 0, 0, 0, 0, 0);
            if (i == 10 || i == 11) begin
                n_checks++;
                if (bus.almost_full !== (i == 11)) begin
                    n_errors++; $display("FAIL full_afull[%0d] got %b exp %b", i, bus.almost_full, i == 11);
                end
            end
        end
        n_checks += 2;
        if (bus.full !== 1'b1)         begin n_errors++; $display("FAIL full_flag got %b exp 1", bus.full); end
        if (bus.count !== CW'(DEPTH))  begin n_errors++; $display("FAIL full_count got %0d exp 16", bus.count); end
        step(1, DW'($urandom), 0, 0, 0, 0, 0);
        n_checks += 3;
        if (bus.overflow !== 1'b1)     begin n_errors++; $display("FAIL full_ovf got %b exp 1", bus.overflow); end
        if (bus.count !== CW'(DEPTH))  begin n_errors++; $display("FAIL full_ovf_count got %0d exp 16", bus.count); end
        if (bus.wr_ack !== 1'b0)       begin n_errors++; $display("FAIL full_ovf_ack got %b exp 0", bus.wr_ack); end
        step(1, DW'($urandom), 1, 0, 0, 0, 0);
        want = exp_q.pop_front();
        n_checks += 4;
        if (bus.count !== CW'(DEPTH - 1)) begin n_errors++; $display("FAIL full_rw_count got %0d exp 15", bus.count); end
        if (bus.wr_ack !== 1'b0)       begin n_errors++; $display("FAIL full_rw_ack got %b exp 0", bus.wr_ack); end
        if (bus.valid !== 1'b1)        begin n_errors++; $display("FAIL full_rw_valid got %b exp 1", bus.valid); end
        if (bus.dout !== want)         begin n_errors++; $display("FAIL full_rw_dout got %h exp %h", bus.dout, want); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(0, '0, 1, 0, 0, 0, 0);
            want = exp_q.pop_front();
            n_checks++;
            if (bus.dout !== want) begin n_errors++; $display("FAIL full_drain[%0d] got %h exp %h", i, bus.dout, want); end
        end
        n_checks++;
        if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL full_ovf_sticky got %b exp 1", bus.overflow); end
    endtask

    task automatic test_underflow();
        step(0, '0, 0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0, 0);
        n_checks += 2;
        if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL unf_set got %b exp 1", bus.underflow); end
        if (bus.valid !== 1'b0)     begin n_errors++; $display("FAIL unf_valid got %b exp 0", bus.valid); end
        step(0, '0, 0, 1, 0, 0, 0);
        n_checks += 2;
        if (bus.underflow !== 1'b0) begin n_errors++; $display("FAIL unf_clear got %b exp 0", bus.underflow); end
        if (bus.count !== '0)       begin n_errors++; $display("FAIL unf_clear_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_timer();
        step(0, '0, 0, 1, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0, 0);
        n_checks++;
        if (timer_on !== 1'b1) begin n_errors++; $display("FAIL tmr_on got %b exp 1", timer_on); end
        idle(100);
        step(0, '0, 0, 0, 0, 1, 0);
        n_checks += 2;
        if (clk_counts !== 64'd102) begin n_errors++; $display("FAIL tmr_102 got %0d exp 102", clk_counts); end
        if (timer_on !== 1'b0)      begin n_errors++; $display("FAIL tmr_off got %b exp 0", timer_on); end
        idle(5);
        n_checks++;
        if (clk_counts !== 64'd102) begin n_errors++; $display("FAIL tmr_hold got %0d exp 102", clk_counts); end
        step(0, '0, 0, 0, 1, 0, 0);
        idle(10);
        step(0, '0, 0, 0, 1, 0, 0);
        n_checks += 2;
        if (clk_counts !== 64'd114) begin n_errors++; $display("FAIL tmr_restart got %0d exp 114", clk_counts); end
        if (timer_on !== 1'b1)      begin n_errors++; $display("FAIL tmr_still_on got %b exp 1", timer_on); end
        step(0, '0, 0, 0, 1, 1, 0);
        n_checks += 2;
        if (clk_counts !== 64'd115) begin n_errors++; $display("FAIL tmr_stop_wins got %0d exp 115", clk_counts); end
        if (timer_on !== 1'b0)      begin n_errors++; $display("FAIL tmr_stop_wins_on got %b exp 0", timer_on); end
        step(0, '0, 0, 0, 1, 1, 0);
        n_checks += 2;
        if (clk_counts !== 64'd115) begin n_errors++; $display("FAIL tmr_idle_both got %0d exp 115", clk_counts); end
        if (timer_on !== 1'b0)      begin n_errors++; $display("FAIL tmr_idle_both_on got %b exp 0", timer_on); end
    endtask

    task automatic test_pattern();
        logic [DW-1:0] words [5];
        int exp_err;
        words = '{32'd0, 32'd1, 32'd2, 32'd7, 32'd4};
`ifdef PATTERN_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        pattern_seed = '0;
        step(0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, words[i], 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1, 0, 0, 0, 0);
            n_checks++;
            if (bus.dout !== words[i]) begin n_errors++; $display("FAIL pat_dout[%0d] got %h exp %h", i, bus.dout, words[i]); end
        end
        idle(1);
        n_checks++;
        if (error_count !== 32'(exp_err)) begin n_errors++; $display("FAIL pat_err got %0d exp %0d", error_count, exp_err); end
        step(0, '0, 0, 0, 0, 0, 1);
        step(1, '0, 0, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0, 0);
        idle(1);
        n_checks++;
        if (error_count !== 32'(exp_err)) begin n_errors++; $display("FAIL pat_reload got %0d exp %0d", error_count, exp_err); end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [DW-1:0] want;
        logic [DW-1:0] wdata;
        int wcnt = 0;
        pattern_seed = DW'($urandom);
        step(0, '0, 0, 1, 0, 0, 0);
        exp_q.delete();
        for (int c = 0; c < 800; c++) begin
            wdata = ($urandom_range(0, 99) < 85) ? pattern_seed + DW'(wcnt) : DW'($urandom);
            step($urandom_range(0, 99) < 55, wdata, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
            wcnt++;
            n_checks += 12;
            if (bus.count !== CW'(mdl_q.size())) begin n_errors++; $display("FAIL rnd_count@%0d got %0d exp %0d", c, bus.count, mdl_q.size()); end
            if (bus.full !== (mdl_q.size() == DEPTH)) begin n_errors++; $display("FAIL rnd_full@%0d got %b", c, bus.full); end
            if (bus.empty !== (mdl_q.size() == 0)) begin n_errors++; $display("FAIL rnd_empty@%0d got %b", c, bus.empty); end
            if (bus.almost_full !== (mdl_q.size() >= DEPTH - 4)) begin n_errors++; $display("FAIL rnd_afull@%0d got %b size %0d", c, bus.almost_full, mdl_q.size()); end
            if (bus.almost_empty !== (mdl_q.size() <= 4)) begin n_errors++; $display("FAIL rnd_aempty@%0d got %b size %0d", c, bus.almost_empty, mdl_q.size()); end
            if (bus.wr_ack !== m_wr_ack) begin n_errors++; $display("FAIL rnd_wr_ack@%0d got %b exp %b", c, bus.wr_ack, m_wr_ack); end
            if (bus.valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid@%0d got %b exp %b", c, bus.valid, m_valid); end
            if (bus.overflow !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf@%0d got %b exp %b", c, bus.overflow, m_ovf); end
            if (bus.underflow !== m_unf) begin n_errors++; $display("FAIL rnd_unf@%0d got %b exp %b", c, bus.underflow, m_unf); end
            if (timer_on !== m_run) begin n_errors++; $display("FAIL rnd_timer_on@%0d got %b exp %b", c, timer_on, m_run); end
            if (clk_counts !== m_clk) begin n_errors++; $display("FAIL rnd_clk@%0d got %0d exp %0d", c, clk_counts, m_clk); end
            if (error_count !== m_err) begin n_errors++; $display("FAIL rnd_err@%0d got %0d exp %0d", c, error_count, m_err); end
            if (m_valid) begin
                want = exp_q.pop_front();
                n_checks++;
                if (bus.dout !== want) begin n_errors++; $display("FAIL rnd_dout@%0d got %h exp %h", c, bus.dout, want); end
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, '0, 0, 1, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(1, DW'($urandom), 0, 0, 0, 0, 0);
        n_checks += 2;
        if (bus.count !== CW'(9)) begin n_errors++; $display("FAIL ar_pre_count got %0d exp 9", bus.count); end
        if (timer_on !== 1'b1)    begin n_errors++; $display("FAIL ar_pre_timer got %b exp 1", timer_on); end
        #2;
        reset_n = 0;
        #1;
        n_checks += 13;
        if (bus.dout !== '0)           begin n_errors++; $display("FAIL ar_dout got %h exp 0", bus.dout); end
        if (bus.valid !== 1'b0)        begin n_errors++; $display("FAIL ar_valid got %b exp 0", bus.valid); end
        if (bus.wr_ack !== 1'b0)       begin n_errors++; $display("FAIL ar_wr_ack got %b exp 0", bus.wr_ack); end
        if (bus.full !== 1'b0)         begin n_errors++; $display("FAIL ar_full got %b exp 0", bus.full); end
        if (bus.empty !== 1'b1)        begin n_errors++; $display("FAIL ar_empty got %b exp 1", bus.empty); end
        if (bus.almost_full !== 1'b0)  begin n_errors++; $display("FAIL ar_afull got %b exp 0", bus.almost_full); end
        if (bus.almost_empty !== 1'b1) begin n_errors++; $display("FAIL ar_aempty got %b exp 1", bus.almost_empty); end
        if (bus.count !== '0)          begin n_errors++; $display("FAIL ar_count got %0d exp 0", bus.count); end
        if (bus.overflow !== 1'b0)     begin n_errors++; $display("FAIL ar_ovf got %b exp 0", bus.overflow); end
        if (bus.underflow !== 1'b0)    begin n_errors++; $display("FAIL ar_unf got %b exp 0", bus.underflow); end
        if (timer_on !== 1'b0)         begin n_errors++; $display("FAIL ar_timer_on got %b exp 0", timer_on); end
        if (clk_counts !== 64'd0)      begin n_errors++; $display("FAIL ar_clk_counts got %0d exp 0", clk_counts); end
        if (error_count !== 32'd0)     begin n_errors++; $display("FAIL ar_error_count got %0d exp 0", error_count); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    initial begin
        reset_n = 0; clear = 0; start_timer = 0; stop_timer = 0;
        reset_pattern = 0; pattern_seed = '0;
        bus.wr_en = 0; bus.rd_en = 0; bus.din = '0;
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_timer();
        test_pattern();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
